// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and sizing for the cpu_mem_arbiter fetch/data sequencer
package arb_pkg;

    localparam int ARB_ADDR_W   = 32;
    localparam int ARB_DATA_W   = 32;
    localparam int ARB_MAX_WAIT = 255;

    function automatic int arb_wait_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

    localparam int ARB_WAIT_W = arb_wait_width(ARB_MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        DATA   = 3'd3,
        COMMIT = 3'd4,
        HALT   = 3'd5
    } arb_state_e;

endpackage

// File: rtl/arb_wait_timer.sv
// rtl/arb_wait_timer.sv - counts consecutive unanswered memory cycles and flags a timeout
module arb_wait_timer
    import arb_pkg::*;
#(
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int W = arb_wait_width(MAX_WAIT);
    localparam logic [W-1:0] CNT_MAX  = W'(MAX_WAIT);
    localparam logic [W-1:0] CNT_LAST = W'(MAX_WAIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!active || ready) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires on the wait cycle that brings the count up to MAX_WAIT.
    assign expired = active && !ready && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - serialises core fetch and LDR/STR onto one memory port, pulses cpu_en per instruction
// Optional ARB_PERF_CNT_EN adds instr_count and wait_count outputs.
module cpu_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] read_data,
    output logic              cpu_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       instr_count,
    output logic [31:0]       wait_count,
`endif
    output logic              err
);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_phase;
    logic              expired;

    assign mem_phase = (state_q == FETCH) || (state_q == DATA);

    arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (mem_phase),
        .ready   (mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_en    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    state_d = EXEC;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end
            EXEC: begin
                if (data_req) begin
                    state_d = DATA;
                end else begin
                    cpu_en  = 1'b1;
                    state_d = FETCH;
                end
            end
            DATA: begin
                // The core holds data_* until cpu_en, so the request stays stable.
                mem_req   = 1'b1;
                mem_we    = data_we;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
                if (mem_ready) begin
                    if (!data_we) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = COMMIT;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end
            COMMIT: begin
                cpu_en  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign instr     = instr_q;
    assign read_data = rdata_q;
    assign err       = err_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (cpu_en) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
        if (mem_phase && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign instr_count = instr_cnt_q;
    assign wait_count  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] read_data;
    logic        cpu_en;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] instr_count;
    logic [31:0] wait_count;
`endif

    int total;
    int bad;

    cpu_mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .read_data  (read_data),
        .cpu_en     (cpu_en),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
`ifdef ARB_PERF_CNT_EN
        .instr_count(instr_count),
        .wait_count (wait_count),
`endif
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; pc = '0; data_req = 0; data_we = 0;
        data_addr = '0; data_wdata = '0; mem_rdata = '0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL rst_cpu_en got=%0h exp=0", cpu_en); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%0h exp=0", instr); end
        total++; if (read_data !== 32'h0) begin bad++; $display("FAIL rst_read_data got=%0h exp=0", read_data); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h exp=0", err); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
        reset = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_mem_req got=%0h exp=0", mem_req); end
        tick();
        mem_rdata = 32'hE081_0002;
        #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch0_req got=%0h exp=1", mem_req); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL fetch0_addr got=%0h exp=0", mem_addr); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL fetch0_cpu_en got=%0h exp=0", cpu_en); end
        tick();
        #1;
        total++; if (instr !== 32'hE081_0002) begin bad++; $display("FAIL exec0_instr got=%0h exp=e0810002", instr); end
        total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL exec0_cpu_en got=%0h exp=1", cpu_en); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL exec0_mem_req got=%0h exp=0", mem_req); end
        tick();
    endtask

    task automatic test_nonmem();
        for (int i = 0; i < 8; i++) begin
            pc = 32'h4;
            #1;
            total++; if (cpu_en !== ((i % 2) == 1)) begin bad++; $display("FAIL nonmem_cpu_en[%0d] got=%0h exp=%0h", i, cpu_en, (i % 2) == 1); end
            total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL nonmem_mem_we[%0d] got=%0h exp=0", i, mem_we); end
            tick();
        end
    endtask

    task automatic test_ldr();
        pc = 32'h8; mem_rdata = 32'hE590_1000; mem_ready = 1'b1;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'hFF;
        #1;
        total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL ldr_fetch_addr got=%0h exp=8", mem_addr); end
        tick();
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL ldr_exec_cpu_en got=%0h exp=0", cpu_en); end
        total++; if (instr !== 32'hE590_1000) begin bad++; $display("FAIL ldr_instr got=%0h exp=e5901000", instr); end
        tick();
        #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL ldr_data_req got=%0h exp=1", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL ldr_data_we got=%0h exp=0", mem_we); end
        total++; if (mem_addr !== 32'hFF) begin bad++; $display("FAIL ldr_data_addr got=%0h exp=ff", mem_addr); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL ldr_data_cpu_en got=%0h exp=0", cpu_en); end
        tick();
        #1;
        total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL ldr_commit_cpu_en got=%0h exp=1", cpu_en); end
        total++; if (read_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ldr_read_data got=%0h exp=ffffffff", read_data); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ldr_commit_req got=%0h exp=0", mem_req); end
        tick();
    endtask

    task automatic test_str();
        pc = 32'hC; mem_rdata = 32'hE580_1000; mem_ready = 1'b1;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'hFF; data_wdata = 32'hFFFF_FFFF;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL str_fetch_we got=%0h exp=0", mem_we); end
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h1234_5678;
        #1;
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL str_exec_cpu_en got=%0h exp=0", cpu_en); end
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL str_we[%0d] got=%0h exp=1", i, mem_we); end
            total++; if (mem_addr !== 32'hFF) begin bad++; $display("FAIL str_addr[%0d] got=%0h exp=ff", i, mem_addr); end
            total++; if (mem_wdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL str_wdata[%0d] got=%0h exp=ffffffff", i, mem_wdata); end
            total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL str_cpu_en[%0d] got=%0h exp=0", i, cpu_en); end
            tick();
        end
        #1;
        total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL str_commit_cpu_en got=%0h exp=1", cpu_en); end
        total++; if (read_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL str_read_data got=%0h exp=ffffffff", read_data); end
        tick();
`ifdef ARB_PERF_CNT_EN
        total++; if (instr_count !== 32'd7) begin bad++; $display("FAIL perf_instr_count got=%0d exp=7", instr_count); end
        total++; if (wait_count !== 32'd3) begin bad++; $display("FAIL perf_wait_count got=%0d exp=3", wait_count); end
`endif
    endtask

    task automatic test_timeout();
        pc = 32'h10; data_req = 1'b0; data_we = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL to_wait_req[%0d] got=%0h exp=1", i, mem_req); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL to_wait_err[%0d] got=%0h exp=0", i, err); end
            tick();
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL halt_req[%0d] got=%0h exp=0", i, mem_req); end
            total++; if (err !== 1'b1) begin bad++; $display("FAIL halt_err[%0d] got=%0h exp=1", i, err); end
            total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL halt_cpu_en[%0d] got=%0h exp=0", i, cpu_en); end
            tick();
        end
`ifdef ARB_PERF_CNT_EN
        total++; if (wait_count !== 32'd7) begin bad++; $display("FAIL perf_wait_halt got=%0d exp=7", wait_count); end
`endif
        reset = 1'b1;
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL halt_reset_err got=%0h exp=0", err); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_idle_req got=%0h exp=0", mem_req); end
        tick();
        pc = 32'h14; mem_rdata = 32'hE580_1000; mem_ready = 1'b1;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40; data_wdata = 32'hA5A5_A5A5;
        tick();
        mem_ready = 1'b0;
        tick();
        #1;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL mid_data_we got=%0h exp=1", mem_we); end
        total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL mid_data_addr got=%0h exp=40", mem_addr); end
        #1;
        reset = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got=%0h exp=0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we got=%0h exp=0", mem_we); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL mid_rst_cpu_en got=%0h exp=0", cpu_en); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL mid_rst_instr got=%0h exp=0", instr); end
`ifdef ARB_PERF_CNT_EN
        total++; if (instr_count !== 32'd0) begin bad++; $display("FAIL mid_rst_instr_count got=%0d exp=0", instr_count); end
`endif
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_nonmem();
        test_ldr();
        test_str();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
